// File: rtl/aux_bit_renderer_if.sv
// aux_bit_renderer_if: sync counters, aux buffer read port and RGB
// outputs of the aux bit-grid renderer, grouped as one bundle.
interface aux_bit_renderer_if #(
    parameter int DATA_WIDTH        = 16,
    parameter int AUX_ADDRESS_WIDTH = 5
);
    logic [9:0]                   h_count_in;
    logic [9:0]                   v_count_in;
    logic                         video_on_in;
    logic [DATA_WIDTH-1:0]        aux_data_in;
    logic [AUX_ADDRESS_WIDTH-1:0] aux_raddress_out;
    logic [3:0]                   red_out;
    logic [3:0]                   green_out;
    logic [3:0]                   blue_out;

    // sync generator + aux buffer side
    modport master (
        output h_count_in,
        output v_count_in,
        output video_on_in,
        output aux_data_in,
        input  aux_raddress_out,
        input  red_out,
        input  green_out,
        input  blue_out
    );

    // renderer side
    modport slave (
        input  h_count_in,
        input  v_count_in,
        input  video_on_in,
        input  aux_data_in,
        output aux_raddress_out,
        output red_out,
        output green_out,
        output blue_out
    );
endinterface

// File: rtl/aux_bit_renderer.sv
// aux_bit_renderer: draws the aux buffer as a bit grid, one word per
// row, one bit per cell, with a grid border on the first pixel/line.
module aux_bit_renderer #(
    parameter int          DATA_WIDTH        = 16,
    parameter int          AUX_ADDRESS_WIDTH = 5,
    parameter int          H_ACTIVE          = 640,
    parameter int          V_ACTIVE          = 480,
    parameter int          V_TOTAL           = 525,
    parameter int          CELL_WIDTH        = 40,
    parameter int          CELL_HEIGHT       = 15,
    parameter logic [11:0] ONE_COLOR         = 12'hFFF,
    parameter logic [11:0] ZERO_COLOR        = 12'h000,
    parameter logic [11:0] GRID_COLOR        = 12'h444
) (
    input logic           clock_in,
    input logic           reset_in,
    aux_bit_renderer_if.slave bus
);

    localparam int PX_W  = (CELL_WIDTH  > 1) ? $clog2(CELL_WIDTH)  : 1;
    localparam int LIC_W = (CELL_HEIGHT > 1) ? $clog2(CELL_HEIGHT) : 1;
    // one spare bit so the column counter can run past the last cell
    localparam int COL_W = $clog2(DATA_WIDTH) + 1;
    localparam int ROW_W = AUX_ADDRESS_WIDTH;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] line_word;
    logic [ROW_W-1:0]      row;
    logic [ROW_W-1:0]      row_next;
    logic [LIC_W-1:0]      line_in_cell;
    logic [LIC_W-1:0]      lic_next;
    logic [COL_W-1:0]      col;
    logic [PX_W-1:0]       px_in_cell;
    logic [ROW_W-1:0]      raddress;
    logic [11:0]           color_next;
    logic [11:0]           color;
    logic [DATA_WIDTH-1:0] shifted_word;
    logic                  cell_bit;
    logic                  trigger;
    logic                  fetch_start;
    logic [9:0]            nl;

    // line-end trigger and the index of the line about to be drawn
    always_comb begin
        trigger = (bus.h_count_in == 10'(H_ACTIVE));
        if (bus.v_count_in == 10'(V_TOTAL - 1)) begin
            nl = 10'd0;
        end else begin
            nl = bus.v_count_in + 10'd1;
        end
        // a trigger outside IDLE is ignored entirely
        fetch_start = trigger && (nl < 10'(V_ACTIVE)) && (state == S_IDLE);
    end

    // next row / line-in-cell, counted rather than divided
    always_comb begin
        row_next = row;
        lic_next = line_in_cell;
        if (nl == 10'd0) begin
            row_next = '0;
            lic_next = '0;
        end else if (line_in_cell == LIC_W'(CELL_HEIGHT - 1)) begin
            lic_next = '0;
            row_next = row + ROW_W'(1);
        end else begin
            lic_next = line_in_cell + LIC_W'(1);
        end
    end

    // line tracking and read address, advanced once per active line
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            row          <= '0;
            line_in_cell <= '0;
            raddress     <= '0;
        end else if (fetch_start) begin
            row          <= row_next;
            line_in_cell <= lic_next;
            raddress     <= row_next;
        end
    end

    // fetch FSM: wait out the registered buffer read, then latch the word
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state     <= S_IDLE;
            line_word <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fetch_start) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    state     <= S_IDLE;
                    line_word <= bus.aux_data_in;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // horizontal cell position, restarted whenever video is off
    always_ff @(posedge clock_in) begin
        if (reset_in || !bus.video_on_in) begin
            col        <= '0;
            px_in_cell <= '0;
        end else if (px_in_cell == PX_W'(CELL_WIDTH - 1)) begin
            px_in_cell <= '0;
            col        <= col + COL_W'(1);
        end else begin
            px_in_cell <= px_in_cell + PX_W'(1);
        end
    end

    // pick the cell colour; shifting left puts the current bit at the
    // MSB and yields 0 for any column past the last cell
    always_comb begin
        shifted_word = line_word << col;
        cell_bit     = shifted_word[DATA_WIDTH-1];
        color_next   = 12'h000;
        if (!bus.video_on_in) begin
            color_next = 12'h000;
        end else if (px_in_cell == '0 || line_in_cell == '0) begin
            color_next = GRID_COLOR;
        end else if (cell_bit) begin
            color_next = ONE_COLOR;
        end else begin
            color_next = ZERO_COLOR;
        end
    end

    // registered RGB, one cycle behind the sync counters
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            color <= 12'h000;
        end else begin
            color <= color_next;
        end
    end

    assign bus.aux_raddress_out = raddress;
    assign bus.red_out          = color[11:8];
    assign bus.green_out        = color[7:4];
    assign bus.blue_out         = color[3:0];

endmodule

// File: tb/tb_aux_bit_renderer.sv
// tb_aux_bit_renderer: drives selected lines of a frame, emulates the
// registered aux buffer and checks pixels against a grid model.
module tb_aux_bit_renderer;

    logic        clk;
    logic        rst;
    logic [15:0] mem [32];
    int          checks;
    int          fails;
    logic [15:0] cur_word;
    int          cur_lic;
    int          last_addr;

    aux_bit_renderer_if #(.DATA_WIDTH(16), .AUX_ADDRESS_WIDTH(5)) bus ();

    aux_bit_renderer dut (
        .clock_in (clk),
        .reset_in (rst),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // aux buffer read port with registered output
    always @(posedge clk) begin
        bus.aux_data_in <= mem[bus.aux_raddress_out];
    end

    function automatic logic [11:0] rgb();
        return {bus.red_out, bus.green_out, bus.blue_out};
    endfunction

    // reference colour: cell = h/40, bit MSB-first, border on px 0 / line 0
    function automatic logic [11:0] model(int h, logic [15:0] word,
                                          int lic);
        int px;
        int c;
        px = h % 40;
        c  = h / 40;
        if (lic == 0 || px == 0) return 12'h444;
        return word[15 - c] ? 12'hFFF : 12'h000;
    endfunction

    task automatic chk(string tag, int val, logic [15:0] obs,
                       logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @%0d: got %h expected %h", tag, val, obs, exp);
        end
    endtask

    task automatic tick(int h, int v, bit von, bit r);
        bus.h_count_in  = 10'(h);
        bus.v_count_in  = 10'(v);
        bus.video_on_in = von;
        rst             = r;
        @(posedge clk);
        #1;
    endtask

    task automatic render(int v, logic [15:0] word, int lic);
        for (int h = 0; h < 640; h++) begin
            tick(h, v, 1'b1, 1'b0);
            chk($sformatf("pix_v%0d", v), h, 16'(rgb()),
                16'(model(h, word, lic)));
        end
    endtask

    // blanking with the trigger; the model's next row is nl/15
    task automatic blank(int v, bit check_addr);
        int nl;
        nl = (v == 524) ? 0 : v + 1;
        for (int h = 640; h < 644; h++) begin
            tick(h, v, 1'b0, 1'b0);
            if (h == 640) begin
                if (check_addr) chk("blank_rgb", v, 16'(rgb()), 16'h0);
                if (nl < 480) begin
                    last_addr = nl / 15;
                    cur_word  = mem[nl / 15];
                    cur_lic   = nl % 15;
                end
                if (check_addr)
                    chk("raddr", v, 16'(bus.aux_raddress_out),
                        16'(last_addr));
            end
        end
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        last_addr = 0;
        cur_word  = 16'h0;
        cur_lic   = 0;
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h8001;
        mem[1] = 16'h5A3C;

        for (int i = 0; i < 3; i++) tick(0, 0, 1'b0, 1'b1);
        chk("reset_rgb", 0, 16'(rgb()), 16'h0);
        chk("reset_raddr", 0, 16'(bus.aux_raddress_out), 16'h0);

        blank(524, 1'b1);
        for (int v = 0; v < 480; v++) begin
            if (v == 45) mem[3] = 16'h0000;
            if (v == 46) mem[3] = 16'hFFFF;
            if (v inside {0, 1, 2, 14, 15, 16, 46, 47, 200, 479})
                render(v, cur_word, cur_lic);
            blank(v, 1'b1);
        end
        chk("last_raddr", 479, 16'(bus.aux_raddress_out), 16'd31);

        for (int v = 480; v < 524; v++) blank(v, 1'b0);
        blank(524, 1'b0);
        for (int v = 0; v < 20; v++) blank(v, 1'b0);
        for (int h = 0; h < 300; h++) tick(h, 20, 1'b1, 1'b0);
        tick(300, 20, 1'b1, 1'b1);
        chk("midreset_rgb", 300, 16'(rgb()), 16'h0);
        chk("midreset_raddr", 300, 16'(bus.aux_raddress_out), 16'h0);
        // counters restart: line_in_cell 0 draws only border colour
        for (int h = 301; h < 640; h++) begin
            tick(h, 20, 1'b1, 1'b0);
            chk("postreset_grid", h, 16'(rgb()), 16'h444);
        end
        tick(640, 20, 1'b0, 1'b0);
        chk("postreset_raddr", 640, 16'(bus.aux_raddress_out), 16'h0);
        for (int h = 641; h < 644; h++) tick(h, 20, 1'b0, 1'b0);
        render(21, mem[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
